// File: rtl/booth_dot_accum_if.sv
`default_nettype none
// ============================================================================
//  Module      : booth_dot_accum_if
//  Description : Bundles the signals between booth_dot_accum and its
//                surroundings: the start request, the Booth multiplier
//                product/rdy/restart path, term index, and the result
//                valid/ready channel.
//                master : the dot-product sequencer (booth_dot_accum)
//                slave  : the surroundings (requester, multiplier, consumer)
//  Signals     : start      requester -> sequencer, 1-cycle go pulse
//                prod       multiplier -> sequencer, signed product
//                prod_rdy   multiplier -> sequencer, level "product done"
//                mul_rst    sequencer -> multiplier, 1-cycle restart pulse
//                term_idx   sequencer -> operand mux, current term index
//                busy       sequencer status, high outside IDLE
//                sum        sequencer -> consumer, signed dot product
//                sum_valid  sequencer -> consumer
//                sum_ready  consumer -> sequencer
//                ovf        sticky signed overflow for the current result
//  Revision    : 1.0  initial release
// ============================================================================
interface booth_dot_accum_if #(
  parameter int PROD_W  = 16,
  parameter int ACC_W   = 24,
  parameter int N_TERMS = 4
);
  localparam int c_IDX_W = $clog2(N_TERMS) + 1;

  logic                     start;
  logic signed [PROD_W-1:0] prod;
  logic                     prod_rdy;
  logic                     mul_rst;
  logic [c_IDX_W-1:0]       term_idx;
  logic                     busy;
  logic signed [ACC_W-1:0]  sum;
  logic                     sum_valid;
  logic                     sum_ready;
  logic                     ovf;

  modport master (
    input  start, prod, prod_rdy, sum_ready,
    output mul_rst, term_idx, busy, sum, sum_valid, ovf
  );

  modport slave (
    output start, prod, prod_rdy, sum_ready,
    input  mul_rst, term_idx, busy, sum, sum_valid, ovf
  );
endinterface
`default_nettype wire

// File: rtl/booth_dot_accum.sv
`default_nettype none
// ============================================================================
//  Module      : booth_dot_accum
//  Description : Sequencer/accumulator behind an 8-bit Booth multiplier.
//                Restarts the multiplier once per term (mul_rst pulse),
//                captures each product on the rising edge of its rdy,
//                and sums N_TERMS products into a signed dot product that
//                is offered on a valid/ready channel. Overflow either
//                saturates (SATURATE=1) or wraps (SATURATE=0) and sets a
//                sticky ovf flag until the next start.
//  Ports       : clk    rising-edge clock
//                reset  asynchronous, active-low reset
//                bus    booth_dot_accum_if.master (see interface header)
//  Revision    : 1.0  initial release
// ============================================================================
module booth_dot_accum #(
  parameter int PROD_W   = 16,
  parameter int ACC_W    = 24,
  parameter int N_TERMS  = 4,
  parameter bit SATURATE = 1'b1
) (
  input  wire logic          clk,
  input  wire logic          reset,
  booth_dot_accum_if.master  bus
);
  localparam int c_IDX_W = $clog2(N_TERMS) + 1;
  localparam logic [c_IDX_W-1:0]     c_LAST = c_IDX_W'(N_TERMS);
  localparam logic signed [ACC_W-1:0] c_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                  r_state;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_sum;
  logic [c_IDX_W-1:0]      r_term_idx;
  logic                    r_ovf;
  logic                    r_sum_valid;
  logic                    r_mul_rst;
  logic                    r_busy;
  logic                    r_prod_rdy_q;

  logic                    w_capture;
  logic signed [ACC_W:0]   w_wide;
  logic                    w_add_ovf;
  logic signed [ACC_W-1:0] w_acc_next;
  logic [c_IDX_W-1:0]      w_idx_next;

  // Only a low-to-high transition of rdy counts as a new product.
  assign w_capture = bus.prod_rdy & ~r_prod_rdy_q;

  // One guard bit: the two top bits disagree exactly on signed overflow.
  assign w_wide = {r_acc[ACC_W-1], r_acc}
                + {{(ACC_W+1-PROD_W){bus.prod[PROD_W-1]}}, bus.prod};
  assign w_add_ovf = w_wide[ACC_W] ^ w_wide[ACC_W-1];
  // On overflow the guard bit carries the true sign, selecting the clamp rail.
  assign w_acc_next = (w_add_ovf && SATURATE) ? (w_wide[ACC_W] ? c_MIN : c_MAX)
                                              : w_wide[ACC_W-1:0];
  assign w_idx_next = r_term_idx + c_IDX_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_acc        <= '0;
      r_sum        <= '0;
      r_term_idx   <= '0;
      r_ovf        <= 1'b0;
      r_sum_valid  <= 1'b0;
      r_mul_rst    <= 1'b0;
      r_busy       <= 1'b0;
      r_prod_rdy_q <= 1'b0;
    end else begin
      r_mul_rst    <= 1'b0;
      r_prod_rdy_q <= bus.prod_rdy;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state    <= S_LAUNCH;
            r_acc      <= '0;
            r_term_idx <= '0;
            r_ovf      <= 1'b0;
            r_mul_rst  <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_LAUNCH: begin
          // rdy may still be high from the previous product; pretend it was
          // already seen so only a fresh low-then-high is captured.
          r_prod_rdy_q <= 1'b1;
          r_state      <= S_WAIT;
        end
        S_WAIT: begin
          if (w_capture) begin
            r_acc      <= w_acc_next;
            r_term_idx <= w_idx_next;
            if (w_add_ovf) begin
              r_ovf <= 1'b1;
            end
            if (w_idx_next == c_LAST) begin
              r_state     <= S_DONE;
              r_sum       <= w_acc_next;
              r_sum_valid <= 1'b1;
            end else begin
              r_state   <= S_LAUNCH;
              r_mul_rst <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (r_sum_valid && bus.sum_ready) begin
            r_sum_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mul_rst   = r_mul_rst;
  assign bus.term_idx  = r_term_idx;
  assign bus.busy      = r_busy;
  assign bus.sum       = r_sum;
  assign bus.sum_valid = r_sum_valid;
  assign bus.ovf       = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_booth_dot_accum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_booth_dot_accum
//  Description : Directed, self-checking bench for booth_dot_accum. Three
//                instances share one stimulus stream: A (ACC_W=24, saturate),
//                B (ACC_W=17, saturate), C (ACC_W=17, wrap). The multiplier
//                is modelled by do_term: on each mul_rst it drops rdy, waits,
//                then presents the product with rdy high.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_booth_dot_accum;
  logic               clk       = 1'b0;
  logic               reset     = 1'b0;
  logic               start     = 1'b0;
  logic               prod_rdy  = 1'b1;
  logic               sum_ready = 1'b0;
  logic signed [15:0] prod      = '0;

  int errors = 0;
  int checks = 0;
  int base   = 0;

  always #5 clk = ~clk;

  booth_dot_accum_if #(.PROD_W(16), .ACC_W(24), .N_TERMS(4)) ifa ();
  booth_dot_accum_if #(.PROD_W(16), .ACC_W(17), .N_TERMS(4)) ifb ();
  booth_dot_accum_if #(.PROD_W(16), .ACC_W(17), .N_TERMS(4)) ifc ();

  assign ifa.start = start;  assign ifa.prod = prod;
  assign ifa.prod_rdy = prod_rdy;  assign ifa.sum_ready = sum_ready;
  assign ifb.start = start;  assign ifb.prod = prod;
  assign ifb.prod_rdy = prod_rdy;  assign ifb.sum_ready = sum_ready;
  assign ifc.start = start;  assign ifc.prod = prod;
  assign ifc.prod_rdy = prod_rdy;  assign ifc.sum_ready = sum_ready;

  booth_dot_accum #(.PROD_W(16), .ACC_W(24), .N_TERMS(4), .SATURATE(1'b1))
    dut_a (.clk(clk), .reset(reset), .bus(ifa));
  booth_dot_accum #(.PROD_W(16), .ACC_W(17), .N_TERMS(4), .SATURATE(1'b1))
    dut_b (.clk(clk), .reset(reset), .bus(ifb));
  booth_dot_accum #(.PROD_W(16), .ACC_W(17), .N_TERMS(4), .SATURATE(1'b0))
    dut_c (.clk(clk), .reset(reset), .bus(ifc));

  // Log of mul_rst pulses and the term index presented with each.
  int         mul_rst_cnt = 0;
  logic [2:0] term_log [0:63];
  always @(negedge clk) begin
    if (ifa.mul_rst === 1'b1) begin
      if (mul_rst_cnt < 64) term_log[mul_rst_cnt] <= ifa.term_idx;
      mul_rst_cnt <= mul_rst_cnt + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One multiplier term: wait for the restart pulse, optionally keep rdy
  // stale-high for a while, drop rdy, optionally poke start mid-wait, then
  // present v with rdy high. Returns at the negedge before the capture edge.
  task automatic do_term(input logic signed [15:0] v, input int gap,
                         input int stale, input int exp_idx, input bit poke);
    int n = 0;
    while (ifa.mul_rst !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("launch_seen", (n < 40), 1);
    chk("launch_term_idx", ifa.term_idx, exp_idx);
    @(negedge clk);
    repeat (stale) @(negedge clk);
    if (stale > 0) begin
      chk("stale_no_capture_idx", ifa.term_idx, exp_idx);
      chk("stale_still_busy", ifa.busy, 1);
    end
    prod_rdy = 1'b0;
    start    = poke;
    @(negedge clk);
    start    = 1'b0;
    repeat (gap - 1) @(negedge clk);
    prod     = v;
    prod_rdy = 1'b1;
  endtask

  initial begin
    // ---- reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_sum_valid", ifa.sum_valid, 0);
    chk("rst_sum", ifa.sum, 0);
    chk("rst_term_idx", ifa.term_idx, 0);
    chk("rst_ovf", ifa.ovf, 0);
    chk("rst_mul_rst", ifa.mul_rst, 0);
    reset = 1'b1;
    @(negedge clk);

    // ---- 100 - 50 + 300 - 7 = 343, first term starts with stale rdy high
    base  = mul_rst_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    do_term(16'sd100, 2, 3, 0, 1'b0);
    do_term(-16'sd50, 1, 0, 1, 1'b0);
    do_term(16'sd300, 3, 0, 2, 1'b0);
    do_term(-16'sd7,  1, 0, 3, 1'b0);
    @(negedge clk);
    chk("t1_sum_valid", ifa.sum_valid, 1);
    chk("t1_sum_a", ifa.sum, 343);
    chk("t1_ovf_a", ifa.ovf, 0);
    chk("t1_sum_c", ifc.sum, 343);
    // consumer stalls for five DONE cycles, accepts on the sixth
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", ifa.sum_valid, 1);
      chk("t3_hold_sum", ifa.sum, 343);
      chk("t3_hold_busy", ifa.busy, 1);
      @(negedge clk);
    end
    sum_ready = 1'b1;
    @(negedge clk);
    sum_ready = 1'b0;
    chk("t3_valid_dropped", ifa.sum_valid, 0);
    chk("t3_busy_dropped", ifa.busy, 0);
    chk("t3_sum_kept", ifa.sum, 343);
    chk("t1_mul_rst_pulses", mul_rst_cnt - base, 4);
    for (int i = 0; i < 4; i++) chk("t1_term_log", term_log[base + i], i);

    // ---- four x 32767 = 131068: A holds it, B clamps, C wraps
    sum_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) do_term(16'sd32767, 1, 0, i, 1'b0);
    @(negedge clk);
    chk("t2_valid_b", ifb.sum_valid, 1);
    chk("t2_sum_a", ifa.sum, 131068);
    chk("t2_ovf_a", ifa.ovf, 0);
    chk("t2_sum_b_sat", ifb.sum, 65535);
    chk("t2_ovf_b", ifb.ovf, 1);
    // 131068 mod 2^17 = 0x1FFFC, i.e. -4 as a 17-bit signed value
    chk("t2_sum_c_wrap", ifc.sum, -4);
    chk("t2_ovf_c", ifc.ovf, 1);
    @(negedge clk);
    chk("t2_accepted", ifa.sum_valid, 0);
    sum_ready = 1'b0;

    // ---- start poked during WAIT is ignored: 10+20+30+40 = 100
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    do_term(16'sd10, 2, 0, 0, 1'b0);
    do_term(16'sd20, 2, 0, 1, 1'b1);
    do_term(16'sd30, 1, 0, 2, 1'b0);
    do_term(16'sd40, 1, 0, 3, 1'b0);
    @(negedge clk);
    chk("t5_sum", ifa.sum, 100);
    chk("t5_valid", ifa.sum_valid, 1);
    sum_ready = 1'b1;
    @(negedge clk);
    sum_ready = 1'b0;
    chk("t5_idle", ifa.busy, 0);
    // back-to-back run right after the handshake
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    do_term(-16'sd1000, 1, 0, 0, 1'b0);
    do_term(-16'sd2000, 2, 0, 1, 1'b0);
    do_term(-16'sd3000, 1, 0, 2, 1'b0);
    do_term(-16'sd4000, 1, 0, 3, 1'b0);
    @(negedge clk);
    chk("t5b_sum_a", ifa.sum, -10000);
    chk("t5b_sum_b", ifb.sum, -10000);
    chk("t5b_ovf", ifa.ovf, 0);
    sum_ready = 1'b1;
    @(negedge clk);
    sum_ready = 1'b0;

    // ---- async reset in the WAIT of term 2
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    do_term(16'sd5, 1, 0, 0, 1'b0);
    do_term(16'sd6, 1, 0, 1, 1'b0);
    @(negedge clk);
    chk("t6_launch2", ifa.mul_rst, 1);
    @(negedge clk);
    prod_rdy = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t6_busy", ifa.busy, 0);
    chk("t6_term_idx", ifa.term_idx, 0);
    chk("t6_sum", ifa.sum, 0);
    chk("t6_sum_valid", ifa.sum_valid, 0);
    chk("t6_mul_rst", ifa.mul_rst, 0);
    chk("t6_sum_b", ifb.sum, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    do_term(16'sd5, 1, 0, 0, 1'b0);
    do_term(16'sd6, 1, 0, 1, 1'b0);
    do_term(16'sd7, 2, 0, 2, 1'b0);
    do_term(16'sd8, 1, 0, 3, 1'b0);
    @(negedge clk);
    chk("t6_fresh_valid", ifa.sum_valid, 1);
    chk("t6_fresh_sum", ifa.sum, 26);
    sum_ready = 1'b1;
    @(negedge clk);
    sum_ready = 1'b0;
    chk("t6_fresh_accept", ifa.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
